// File: rtl/turn_signal_ctrl.sv
// Six-lamp tail-light controller: arbitrates left/right/hazard requests in IDLE and steps the
// granted pattern every TICK_DIV cycles. Define TURN_HAZARD_EN to compile in hazard support.
module turn_signal_ctrl #(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic left,
  input  logic right,
  input  logic hazard,
  output logic la,
  output logic lb,
  output logic lc,
  output logic ra,
  output logic rb,
  output logic rc,
  output logic busy
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

  typedef enum logic [3:0] {
    StIdle = 4'd0,
    StL1   = 4'd1,
    StL2   = 4'd2,
    StL3   = 4'd3,
    StLoff = 4'd4,
    StR1   = 4'd5,
    StR2   = 4'd6,
    StR3   = 4'd7,
    StRoff = 4'd8
`ifdef TURN_HAZARD_EN
    ,
    StHon  = 4'd9,
    StHoff = 4'd10
`endif
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            last_right_q, last_right_d;
  logic [5:0]      lamps_q;
  logic            busy_q;
  logic            at_end;
  logic            haz_req;

`ifdef TURN_HAZARD_EN
  assign haz_req = hazard;
`else
  logic unused_hazard;
  assign unused_hazard = hazard;
  assign haz_req       = 1'b0;
`endif

  // Lamp order is {lc, lb, la, ra, rb, rc}.
  function automatic logic [5:0] lamps_of(state_e s);
    logic [5:0] l;
    case (s)
      StL1:    l = 6'b001000;
      StL2:    l = 6'b011000;
      StL3:    l = 6'b111000;
      StR1:    l = 6'b000100;
      StR2:    l = 6'b000110;
      StR3:    l = 6'b000111;
`ifdef TURN_HAZARD_EN
      StHon:   l = 6'b111111;
`endif
      default: l = 6'b000000;
    endcase
    return l;
  endfunction

  assign at_end = (cnt_q == CntMax);

  always_comb begin
    state_d      = state_q;
    last_right_d = last_right_q;
    case (state_q)
      StIdle: begin
        if (haz_req) begin
`ifdef TURN_HAZARD_EN
          state_d = StHon;
`endif
        end else if (left && (!right || last_right_q)) begin
          state_d      = StL1;
          last_right_d = 1'b0;
        end else if (right) begin
          state_d      = StR1;
          last_right_d = 1'b1;
        end
      end
      StL1:    state_d = at_end ? StL2   : StL1;
      StL2:    state_d = at_end ? StL3   : StL2;
      StL3:    state_d = at_end ? StLoff : StL3;
      StLoff:  state_d = at_end ? StIdle : StLoff;
      StR1:    state_d = at_end ? StR2   : StR1;
      StR2:    state_d = at_end ? StR3   : StR2;
      StR3:    state_d = at_end ? StRoff : StR3;
      StRoff:  state_d = at_end ? StIdle : StRoff;
`ifdef TURN_HAZARD_EN
      StHon:   state_d = at_end ? StHoff : StHon;
      StHoff:  state_d = at_end ? StIdle : StHoff;
`endif
      default: state_d = StIdle;
    endcase
    // Sequences never self-loop across a step, so a state change always restarts the count.
    cnt_cnt_default: begin
    end
    if ((state_d == state_q) && (state_q != StIdle)) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      last_right_q <= 1'b1;
      lamps_q      <= 6'b000000;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_right_q <= last_right_d;
      lamps_q      <= lamps_of(state_d);
      busy_q       <= (state_d != StIdle);
    end
  end

  assign {lc, lb, la, ra, rb, rc} = lamps_q;
  assign busy                     = busy_q;

endmodule

// File: tb/tb_turn_signal_ctrl.sv
// Randomized and directed bench for turn_signal_ctrl; runs TICK_DIV=4 and TICK_DIV=1 instances
// side by side against a cycle-position reference model.
module tb_turn_signal_ctrl;

`ifdef TURN_HAZARD_EN
  localparam bit HazEn = 1'b1;
`else
  localparam bit HazEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n, left, right, hazard;
  logic la4, lb4, lc4, ra4, rb4, rc4, busy4;
  logic la1, lb1, lc1, ra1, rb1, rc1, busy1;

  int checks = 0;
  int errors = 0;

  // Model: active sequence kind (0 none, 1 left, 2 right, 3 hazard) and cycles since grant.
  int         m_kind[2];
  int         m_pos[2];
  bit         m_lr[2];
  logic [6:0] m_exp[2];

  always #5 clk = ~clk;

  turn_signal_ctrl #(.TICK_DIV(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .left(left), .right(right), .hazard(hazard),
    .la(la4), .lb(lb4), .lc(lc4), .ra(ra4), .rb(rb4), .rc(rc4), .busy(busy4)
  );

  turn_signal_ctrl #(.TICK_DIV(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .left(left), .right(right), .hazard(hazard),
    .la(la1), .lb(lb1), .lc(lc1), .ra(ra1), .rb(rb1), .rc(rc1), .busy(busy1)
  );

  function automatic logic [6:0] obs4();
    return {busy4, lc4, lb4, la4, ra4, rb4, rc4};
  endfunction

  function automatic logic [6:0] obs1();
    return {busy1, lc1, lb1, la1, ra1, rb1, rc1};
  endfunction

  function automatic int nsteps(int kind);
    return (kind == 3) ? 2 : 4;
  endfunction

  function automatic logic [5:0] pat(int kind, int step);
    logic [5:0] p;
    p = 6'b000000;
    if (kind == 1) begin
      if (step == 0) p = 6'b001000;
      else if (step == 1) p = 6'b011000;
      else if (step == 2) p = 6'b111000;
    end else if (kind == 2) begin
      if (step == 0) p = 6'b000100;
      else if (step == 1) p = 6'b000110;
      else if (step == 2) p = 6'b000111;
    end else if (kind == 3) begin
      if (step == 0) p = 6'b111111;
    end
    return p;
  endfunction

  task automatic tick();
    int td;
    @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      td = (m == 0) ? 4 : 1;
      if (!reset_n) begin
        m_kind[m] = 0;
        m_pos[m]  = 0;
        m_lr[m]   = 1'b1;
        m_exp[m]  = 7'b0;
      end else begin
        if (m_kind[m] == 0) begin
          m_pos[m] = 0;
          if (HazEn && hazard) begin
            m_kind[m] = 3;
          end else if (left && (!right || m_lr[m])) begin
            m_kind[m] = 1;
            m_lr[m]   = 1'b0;
          end else if (right) begin
            m_kind[m] = 2;
            m_lr[m]   = 1'b1;
          end
        end else begin
          m_pos[m]++;
        end
        if (m_kind[m] == 0) begin
          m_exp[m] = 7'b0;
        end else if (m_pos[m] == nsteps(m_kind[m]) * td) begin
          m_exp[m]  = 7'b0;
          m_kind[m] = 0;
        end else begin
          m_exp[m] = {1'b1, pat(m_kind[m], m_pos[m] / td)};
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    left    = 1'b0;
    right   = 1'b0;
    hazard  = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (obs4() !== 7'b0) begin
      errors++;
      $display("FAIL reset_t4 got %b want %b", obs4(), 7'b0);
    end
    checks++;
    if (obs1() !== 7'b0) begin
      errors++;
      $display("FAIL reset_t1 got %b want %b", obs1(), 7'b0);
    end
  endtask

  task automatic test_left_pulse();
    do_reset();
    left = 1'b1;
    for (int i = 0; i < 22; i++) begin
      tick();
      left = 1'b0;
      checks++;
      if (obs4() !== m_exp[0]) begin
        errors++;
        $display("FAIL left_pulse_t4 cyc %0d got %b want %b", i, obs4(), m_exp[0]);
      end
      checks++;
      if (obs1() !== m_exp[1]) begin
        errors++;
        $display("FAIL left_pulse_t1 cyc %0d got %b want %b", i, obs1(), m_exp[1]);
      end
    end
  endtask

  task automatic test_tie();
    do_reset();
    left  = 1'b1;
    right = 1'b1;
    tick();
    checks++;
    if (obs4() !== 7'b1001000) begin
      errors++;
      $display("FAIL tie_first_left got %b want %b", obs4(), 7'b1001000);
    end
    for (int i = 0; i < 60; i++) begin
      tick();
      checks++;
      if (obs4() !== m_exp[0]) begin
        errors++;
        $display("FAIL tie_t4 cyc %0d got %b want %b", i, obs4(), m_exp[0]);
      end
      checks++;
      if (obs1() !== m_exp[1]) begin
        errors++;
        $display("FAIL tie_t1 cyc %0d got %b want %b", i, obs1(), m_exp[1]);
      end
    end
  endtask

  task automatic test_hazard();
    do_reset();
    left   = 1'b1;
    right  = 1'b1;
    hazard = 1'b1;
    for (int i = 0; i < 40; i++) begin
      // Drop hazard partway so the following tie exposes last_right.
      if (i == 20) hazard = 1'b0;
      tick();
      checks++;
      if (obs4() !== m_exp[0]) begin
        errors++;
        $display("FAIL hazard_t4 cyc %0d got %b want %b", i, obs4(), m_exp[0]);
      end
      checks++;
      if (obs1() !== m_exp[1]) begin
        errors++;
        $display("FAIL hazard_t1 cyc %0d got %b want %b", i, obs1(), m_exp[1]);
      end
    end
  endtask

  task automatic test_ignore();
    do_reset();
    left = 1'b1;
    for (int i = 0; i < 35; i++) begin
      tick();
      left = 1'b0;
      if (i == 4) right = 1'b1;
      checks++;
      if (obs4() !== m_exp[0]) begin
        errors++;
        $display("FAIL ignore_t4 cyc %0d got %b want %b", i, obs4(), m_exp[0]);
      end
    end
    right = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    right = 1'b1;
    tick();
    right = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    checks++;
    if (obs4() !== 7'b0) begin
      errors++;
      $display("FAIL reset_mid got %b want %b", obs4(), 7'b0);
    end
    left  = 1'b1;
    right = 1'b1;
    tick();
    checks++;
    if (obs4() !== 7'b1001000) begin
      errors++;
      $display("FAIL reset_mid_tie got %b want %b", obs4(), 7'b1001000);
    end
    left  = 1'b0;
    right = 1'b0;
  endtask

  task automatic test_tick1();
    do_reset();
    left = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      checks++;
      if (obs1() !== m_exp[1]) begin
        errors++;
        $display("FAIL tick1 cyc %0d got %b want %b", i, obs1(), m_exp[1]);
      end
    end
    left = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      left    = ($urandom_range(0, 2) != 0);
      right   = ($urandom_range(0, 2) != 0);
      hazard  = ($urandom_range(0, 5) == 0);
      reset_n = ($urandom_range(0, 60) != 0);
      tick();
      checks++;
      if (obs4() !== m_exp[0]) begin
        errors++;
        $display("FAIL random_t4 cyc %0d got %b want %b", i, obs4(), m_exp[0]);
      end
      checks++;
      if (obs1() !== m_exp[1]) begin
        errors++;
        $display("FAIL random_t1 cyc %0d got %b want %b", i, obs1(), m_exp[1]);
      end
    end
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    left    = 1'b0;
    right   = 1'b0;
    hazard  = 1'b0;
    @(negedge clk);
    test_reset();
    test_left_pulse();
    test_tie();
    test_hazard();
    test_ignore();
    test_reset_mid();
    test_tick1();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
